alu_decode_stage: RTL and testbench

Decode stage that produces the ALU's control and operand-select inputs for the rv32 core. It accepts a 32-bit RV32I instruction over a valid/ready handshake, registers it, and presents `fop`, `imm_gen`, `alu_mux_en`, `u` and register addresses to the execute stage. It also presents the companion control bits to the execute stage. Single pipeline register, one-cycle latency, full throughput, with flush and illegal-instruction flagging.

---
 rtl/alu_decode_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode stage feeding the ALU/execute stage.
// One registered output bundle behind a valid/ready handshake, with flush
// and illegal-encoding flagging. Illegal words still transfer as a bundle
// carrying only register addresses and the illegal flag.
module alu_decode_stage (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] inst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  fop,
  output logic [31:0] imm_gen,
  output logic        alu_mux_en,
  output logic        u,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_we,
  output logic        slt_sel,
  output logic [2:0]  br_funct3,
  output logic        is_branch,
  output logic        is_load,
  output logic        is_store,
  output logic        illegal
);

  typedef enum logic [3:0] {
    FOP_ADD = 4'd0,
    FOP_SUB = 4'd1,
    FOP_SLL = 4'd2,
    FOP_SRL = 4'd3,
    FOP_SRA = 4'd4,
    FOP_AND = 4'd5,
    FOP_OR  = 4'd6,
    FOP_XOR = 4'd7,
    FOP_IMM = 4'd8
  } fop_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    fop_e        fop;
    logic [31:0] imm;
    logic        alu_mux_en;
    logic        u;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        slt_sel;
    logic [2:0]  br_funct3;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } bundle_t;

  // funct3 -> ALU op shared by OP and OP-IMM; 'alt' selects SUB/SRA variants.
  function automatic fop_e arith_fop(input logic [2:0] f3, input logic alt);
    fop_e r;
    case (f3)
      3'b000:  r = alt ? FOP_SUB : FOP_ADD;
      3'b001:  r = FOP_SLL;
      3'b010:  r = FOP_SUB;
      3'b011:  r = FOP_SUB;
      3'b100:  r = FOP_XOR;
      3'b101:  r = alt ? FOP_SRA : FOP_SRL;
      3'b110:  r = FOP_OR;
      default: r = FOP_AND;
    endcase
    return r;
  endfunction

  opcode_e     opc;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        f7_zero;
  logic        f7_alt;
  logic        f3_is_slt;
  logic        f3_is_shift;
  logic [31:0] imm_i;
  logic [31:0] imm_sh;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic        legal;
  bundle_t     dec;

  logic        accept;
  logic        out_valid_d, out_valid_q;
  bundle_t     bundle_d, bundle_q;

  assign opc         = opcode_e'(inst[6:0]);
  assign funct3      = inst[14:12];
  assign funct7      = inst[31:25];
  assign f7_zero     = (funct7 == 7'b0000000);
  assign f7_alt      = (funct7 == 7'b0100000);
  assign f3_is_slt   = (funct3[2:1] == 2'b01);
  assign f3_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_sh = {27'b0, inst[24:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};

  // Combinational decode of the incoming word into a candidate bundle.
  always_comb begin
    dec       = '0;
    dec.rs1   = inst[19:15];
    dec.rs2   = inst[24:20];
    dec.rd    = inst[11:7];
    legal     = 1'b1;
    case (opc)
      OPC_OP: begin
        dec.reg_we  = 1'b1;
        dec.fop     = arith_fop(funct3, f7_alt);
        dec.slt_sel = f3_is_slt;
        dec.u       = (funct3 == 3'b011);
        legal       = f7_zero || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        dec.reg_we     = 1'b1;
        dec.alu_mux_en = 1'b1;
        dec.slt_sel    = f3_is_slt;
        dec.u          = (funct3 == 3'b011);
        if (f3_is_shift) begin
          // funct7 is only an opcode extension for shift-immediates
          dec.fop = arith_fop(funct3, f7_alt && (funct3 == 3'b101));
          dec.imm = imm_sh;
          legal   = f7_zero || (f7_alt && (funct3 == 3'b101));
        end else begin
          dec.fop = arith_fop(funct3, 1'b0);
          dec.imm = imm_i;
        end
      end
      OPC_LUI: begin
        dec.fop        = FOP_IMM;
        dec.imm        = imm_u;
        dec.alu_mux_en = 1'b1;
        dec.reg_we     = 1'b1;
      end
      OPC_LOAD: begin
        dec.fop        = FOP_ADD;
        dec.imm        = imm_i;
        dec.alu_mux_en = 1'b1;
        dec.reg_we     = 1'b1;
        dec.is_load    = 1'b1;
      end
      OPC_STORE: begin
        dec.fop        = FOP_ADD;
        dec.imm        = imm_s;
        dec.alu_mux_en = 1'b1;
        dec.is_store   = 1'b1;
      end
      OPC_BRANCH: begin
        dec.fop       = FOP_SUB;
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        dec.br_funct3 = funct3;
        dec.u         = (funct3[2:1] == 2'b11);
        legal         = !f3_is_slt;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.rs1     = inst[19:15];
      dec.rs2     = inst[24:20];
      dec.rd      = inst[11:7];
      dec.illegal = 1'b1;
    end
  end

  // Handshake and next-state of the output register; flush beats accept and hold.
  always_comb begin
    in_ready = !flush && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    bundle_d = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output pipeline register with asynchronous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign fop        = bundle_q.fop;
  assign imm_gen    = bundle_q.imm;
  assign alu_mux_en = bundle_q.alu_mux_en;
  assign u          = bundle_q.u;
  assign rs1        = bundle_q.rs1;
  assign rs2        = bundle_q.rs2;
  assign rd         = bundle_q.rd;
  assign reg_we     = bundle_q.reg_we;
  assign slt_sel    = bundle_q.slt_sel;
  assign br_funct3  = bundle_q.br_funct3;
  assign is_branch  = bundle_q.is_branch;
  assign is_load    = bundle_q.is_load;
  assign is_store   = bundle_q.is_store;
  assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: randomized scoreboard bench for alu_decode_stage.
// The driver pushes a reference-model decode on every accepted word; a
// separate monitor pops and compares whenever the DUT presents a bundle.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] inst = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  fop;
  logic [31:0] imm_gen;
  logic        alu_mux_en, u, reg_we, slt_sel;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  br_funct3;
  logic        is_branch, is_load, is_store, illegal;

  alu_decode_stage dut (
    .clk(clk), .nrst(nrst), .inst(inst), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .fop(fop),
    .imm_gen(imm_gen), .alu_mux_en(alu_mux_en), .u(u), .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_we(reg_we), .slt_sel(slt_sel), .br_funct3(br_funct3), .is_branch(is_branch),
    .is_load(is_load), .is_store(is_store), .illegal(illegal)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [3:0]  fop;
    logic [31:0] imm;
    logic        mux;
    logic        u;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic        slt;
    logic [2:0]  bf3;
    logic        br, ld, st, ill;
  } exp_t;

  // funct3 -> ALU op for the plain (funct7 = 0) arithmetic forms
  localparam logic [3:0] BASE_OP [8] = '{4'd0, 4'd2, 4'd1, 4'd1, 4'd7, 4'd3, 4'd6, 4'd5};

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mdl_valid = 1'b0;

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    int  simm;
    bit  ok = 1'b1;
    e = '0;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    case (opc)
      7'h33: begin
        e.we = 1; e.fop = BASE_OP[f3];
        e.slt = (f3 == 2 || f3 == 3); e.u = (f3 == 3);
        if (f7 == 7'h20 && f3 == 0) e.fop = 4'd1;
        else if (f7 == 7'h20 && f3 == 5) e.fop = 4'd4;
        else if (f7 != 0) ok = 0;
      end
      7'h13: begin
        e.we = 1; e.mux = 1; e.fop = BASE_OP[f3];
        e.slt = (f3 == 2 || f3 == 3); e.u = (f3 == 3);
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(w[24:20]);
          if (f3 == 5 && f7 == 7'h20) e.fop = 4'd4;
          else if (f7 != 0) ok = 0;
        end else begin
          simm = $signed(w[31:20]);
          e.imm = simm;
        end
      end
      7'h37: begin
        e.fop = 4'd8; e.imm = w & 32'hFFFFF000; e.mux = 1; e.we = 1;
      end
      7'h03: begin
        simm = $signed(w[31:20]);
        e.imm = simm; e.mux = 1; e.we = 1; e.ld = 1;
      end
      7'h23: begin
        simm = $signed({w[31:25], w[11:7]});
        e.imm = simm; e.mux = 1; e.st = 1;
      end
      7'h63: begin
        simm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        e.fop = 4'd1; e.imm = simm; e.br = 1; e.bf3 = f3; e.u = (f3 >= 6);
        ok = !(f3 == 2 || f3 == 3);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0;
      e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.ill = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    w[6:0] = 7'h33;
      2, 3:    w[6:0] = 7'h13;
      4:       w[6:0] = 7'h37;
      5:       w[6:0] = 7'h03;
      6:       w[6:0] = 7'h23;
      7, 8:    w[6:0] = 7'h63;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0, 1:    w[31:25] = 7'h00;
      2:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    chk({tag, " fop"}, 32'(fop), 0);
    chk({tag, " imm_gen"}, imm_gen, 0);
    chk({tag, " misc"}, {alu_mux_en, u, reg_we, slt_sel, is_branch, is_load, is_store, illegal}, 0);
    chk({tag, " regs"}, {rs1, rs2, rd, br_funct3}, 0);
  endtask

  // One cycle of stimulus: drive after the falling edge, settle, then check
  // in_ready against the handshake rule and record any accepted word.
  task automatic drive_cycle(input logic [31:0] w, input bit iv, input bit ordy, input bit fl);
    bit exp_rdy, acc;
    @(negedge clk);
    inst = w; in_valid = iv; out_ready = ordy; flush = fl;
    #3;
    exp_rdy = !fl && (!mdl_valid || ordy);
    acc = iv && exp_rdy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (acc) sb.push_back(ref_decode(w));
    if (fl) mdl_valid = 0;
    else if (acc) mdl_valid = 1;
    else if (ordy) mdl_valid = 0;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    in_valid = 0; flush = 0; out_ready = 0;
    #1 nrst = 0;
    #2 chk_reset_outputs("async_reset");
    sb.delete();
    mdl_valid = 0;
    @(negedge clk);
    #1 nrst = 1;
  endtask

  // Monitor: compare the presented bundle with the scoreboard head each cycle.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (nrst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("out_valid", 32'(out_valid), 0);
        end else begin
          e = sb[0];
          n_vec++;
          chk("fop", 32'(fop), 32'(e.fop));
          chk("imm_gen", imm_gen, e.imm);
          chk("alu_mux_en/u/reg_we/slt_sel", {alu_mux_en, u, reg_we, slt_sel},
              {e.mux, e.u, e.we, e.slt});
          chk("rs1/rs2/rd", {rs1, rs2, rd}, {e.rs1, e.rs2, e.rd});
          chk("br_funct3", 32'(br_funct3), 32'(e.bf3));
          chk("class/illegal", {is_branch, is_load, is_store, illegal},
              {e.br, e.ld, e.st, e.ill});
          if (out_ready || flush) void'(sb.pop_front());
        end
      end else if (sb.size() != 0) begin
        chk("out_valid", 32'(out_valid), 1);
        void'(sb.pop_front());
      end else begin
        n_vec++;
      end
    end
  end

  initial begin
    #3 chk_reset_outputs("reset");
    @(negedge clk);
    #1 nrst = 1;

    // directed words from the decode rules
    drive_cycle(32'hFFB00093, 1, 1, 0);   // ADDI x1,x0,-5
    drive_cycle(32'h402081B3, 1, 1, 0);   // SUB x3,x1,x2
    drive_cycle(32'h40435293, 1, 1, 0);   // SRAI x5,x6,4
    drive_cycle(32'h00435293, 1, 1, 0);   // SRLI x5,x6,4
    drive_cycle(32'h123453B7, 1, 1, 0);   // LUI x7,0x12345
    drive_cycle(32'h0020E463, 1, 1, 0);   // BLTU x1,x2,+8
    drive_cycle(32'h0020A1B3, 1, 1, 0);   // SLT x3,x1,x2
    drive_cycle(32'h4020C1B3, 1, 1, 0);   // funct7=0100000 on XOR: illegal

    // backpressure: hold three cycles, then release
    drive_cycle(32'h402081B3, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive_cycle(32'h123453B7, 1, 0, 0);
    drive_cycle(32'h123453B7, 1, 1, 0);
    drive_cycle(32'h0, 0, 1, 0);

    // illegal bundle then flush while it is held
    drive_cycle(32'h0000007F, 1, 0, 0);
    drive_cycle(32'hFFB00093, 1, 0, 1);
    drive_cycle(32'h0, 0, 1, 0);
    drive_cycle(32'h0, 0, 1, 0);

    // reset with a bundle in flight
    drive_cycle(32'hFFB00093, 1, 0, 0);
    pulse_reset();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive_cycle(rand_inst(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
      if (i == 750) pulse_reset();
    end

    for (int i = 0; i < 3; i++) drive_cycle(32'h0, 0, 1, 0);
    @(negedge clk);
    #3 chk("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
